smash_noc_router_buf: RTL and testbench

Parametrised, buffered 5-port mesh router that replaces the unbuffered `smash_noc` tile in an arbitrary NUM_ROWS × NUM_COLUMNS mesh. It accepts flits on up/down/left/right/local ports and stores them in per-input FIFOs. Each output has a round-robin arbiter and a registered output stage, and routing is dimension-ordered XY. The local port is the attachment point for a processing element.

---
 rtl/smash_noc_pkg.sv | 78 +++++++
 rtl/smash_noc_fifo.sv | 60 ++++++
 rtl/smash_noc_router_buf.sv | 123 ++++++++++++
 tb/tb_smash_noc_router_buf.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smash_noc_pkg.sv
// Shared definitions for the buffered mesh router: port indices, flit field
// offsets, XY route decode and round-robin helpers.
package smash_noc_pkg;

    localparam int unsigned NUM_PORTS = 5;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_UP    = 3'd1,
        PORT_DOWN  = 3'd2,
        PORT_LEFT  = 3'd3,
        PORT_RIGHT = 3'd4
    } port_e;

    // Flit layout is {row, col, data} with row in the MSBs.
    function automatic int unsigned flit_width(input int unsigned addr_size,
                                               input int unsigned data_size);
        return 2 * addr_size + data_size;
    endfunction

    function automatic int unsigned flit_row_lsb(input int unsigned addr_size,
                                                 input int unsigned data_size);
        return addr_size + data_size;
    endfunction

    function automatic int unsigned flit_col_lsb(input int unsigned data_size);
        return data_size;
    endfunction

    // Dimension-ordered XY decode; one-hot output request, zero for an
    // address outside the mesh.
    function automatic logic [4:0] route(input int unsigned row,
                                         input int unsigned col,
                                         input int unsigned my_row,
                                         input int unsigned my_col,
                                         input int unsigned num_rows,
                                         input int unsigned num_cols);
        logic [4:0] r;
        r = '0;
        if (row >= num_rows || col >= num_cols) begin
            r = '0;
        end else if (col > my_col) begin
            r[PORT_RIGHT] = 1'b1;
        end else if (col < my_col) begin
            r[PORT_LEFT] = 1'b1;
        end else if (row > my_row) begin
            r[PORT_UP] = 1'b1;
        end else if (row < my_row) begin
            r[PORT_DOWN] = 1'b1;
        end else begin
            r[PORT_LOCAL] = 1'b1;
        end
        return r;
    endfunction

    // First requester at or above ptr, wrapping at NUM_PORTS.
    function automatic logic [2:0] rr_pick(input logic [4:0] req,
                                           input logic [2:0] ptr);
        logic [2:0]  g;
        logic        found;
        int unsigned idx;
        g     = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (32'(ptr) + k) % NUM_PORTS;
            if (!found && req[3'(idx)]) begin
                g     = 3'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [2:0] rr_next(input logic [2:0] g);
        return (g == PORT_RIGHT) ? 3'd0 : g + 3'd1;
    endfunction

endpackage

// File: rtl/smash_noc_fifo.sv
// Synchronous FIFO with async active-low reset; head is shown
// combinationally while not empty. DEPTH must be a power of two.
module smash_noc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array, written on accepted pushes only.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/smash_noc_router_buf.sv
// Buffered 5-port XY mesh router: per-input FIFOs, per-output round-robin
// arbiters and registered output stages. Define SMASH_NOC_STATS_EN to add
// the saturating o_drop_cnt counter of flits with out-of-mesh addresses.
module smash_noc_router_buf
    import smash_noc_pkg::*;
#(
    parameter int unsigned ADDR_SIZE       = 2,
    parameter int unsigned DATA_SIZE       = 32,
    parameter int unsigned NUM_ROWS        = 2,
    parameter int unsigned NUM_COLUMNS     = 2,
    parameter int unsigned ROUTER_ROW_ADDR = 0,
    parameter int unsigned ROUTER_COL_ADDR = 0,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [4:0]                             i_valid,
    input  logic [5*(2*ADDR_SIZE+DATA_SIZE)-1:0]   i_flit,
    output logic [4:0]                             o_ready,
    output logic [4:0]                             o_valid,
    output logic [5*(2*ADDR_SIZE+DATA_SIZE)-1:0]   o_flit,
    input  logic [4:0]                             i_ready
`ifdef SMASH_NOC_STATS_EN
    ,
    output logic [15:0]                            o_drop_cnt
`endif
);

    localparam int unsigned FLIT    = flit_width(ADDR_SIZE, DATA_SIZE);
    localparam int unsigned ROW_LSB = flit_row_lsb(ADDR_SIZE, DATA_SIZE);
    localparam int unsigned COL_LSB = flit_col_lsb(DATA_SIZE);

    logic [FLIT-1:0] w_head    [NUM_PORTS];
    logic [4:0]      w_req     [NUM_PORTS];   // per input: requested output, one-hot
    logic [4:0]      w_gnt_vec [NUM_PORTS];   // per output: input popped this edge, one-hot
    logic [4:0]      w_full;
    logic [4:0]      w_empty;
    logic [4:0]      w_pop;
    logic [4:0]      w_drop;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        logic [4:0] w_dest;

        smash_noc_fifo #(
            .WIDTH (FLIT),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_push  (i_valid[p]),
            .i_data  (i_flit[p*FLIT +: FLIT]),
            .i_pop   (w_pop[p]),
            .o_full  (w_full[p]),
            .o_empty (w_empty[p]),
            .o_head  (w_head[p])
        );

        assign w_dest   = route(32'(w_head[p][ROW_LSB +: ADDR_SIZE]),
                                32'(w_head[p][COL_LSB +: ADDR_SIZE]),
                                ROUTER_ROW_ADDR, ROUTER_COL_ADDR,
                                NUM_ROWS, NUM_COLUMNS);
        assign w_req[p]  = w_empty[p] ? '0 : w_dest;
        assign w_drop[p] = !w_empty[p] && (w_dest == '0);
        // A head requests one output at most, so at most one grant term is set.
        assign w_pop[p]  = w_drop[p] | w_gnt_vec[0][p] | w_gnt_vec[1][p] |
                           w_gnt_vec[2][p] | w_gnt_vec[3][p] | w_gnt_vec[4][p];
        assign o_ready[p] = !w_full[p];
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [4:0]      w_cand;
        logic [2:0]      w_gnt;
        logic            w_load;
        logic            r_valid;
        logic [FLIT-1:0] r_flit;
        logic [2:0]      r_ptr;

        assign w_cand = {w_req[4][o], w_req[3][o], w_req[2][o], w_req[1][o], w_req[0][o]};
        assign w_gnt  = rr_pick(w_cand, r_ptr);
        assign w_load = !r_valid || i_ready[o];
        assign w_gnt_vec[o] = (w_load && (|w_cand)) ? (5'b00001 << w_gnt) : '0;

        // Output stage: refill when empty or being consumed, otherwise hold.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_valid <= 1'b0;
                r_flit  <= '0;
                r_ptr   <= '0;
            end else if (w_load) begin
                r_valid <= |w_cand;
                if (|w_cand) begin
                    r_flit <= w_head[w_gnt];
                    r_ptr  <= rr_next(w_gnt);
                end
            end
        end

        assign o_valid[o]              = r_valid;
        assign o_flit[o*FLIT +: FLIT]  = r_flit;
    end

`ifdef SMASH_NOC_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [2:0]  w_drop_num;
    logic [16:0] w_drop_sum;

    assign w_drop_num = {2'b00, w_drop[0]} + {2'b00, w_drop[1]} + {2'b00, w_drop[2]} +
                        {2'b00, w_drop[3]} + {2'b00, w_drop[4]};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {14'b0, w_drop_num};

    // Drop counter: add every drop of this edge, saturating at all ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_smash_noc_router_buf.sv
// Bench for smash_noc_router_buf: directed steps followed by a randomized
// run checked against a per-(source, destination) flit scoreboard.
module tb_smash_noc_router_buf;

    localparam int FW = 36;

    logic         clk;
    logic         rst_n;
    logic [4:0]   valid, oready, ovalid, iready;
    logic [179:0] iflit, oflit;
    logic [4:0]   v3, or3, ov3, ir3;
    logic [179:0] f3, of3;
`ifdef SMASH_NOC_STATS_EN
    logic [15:0]  dc, dc3;
`endif

    int n_checks;
    int n_fail;
    int seq;

    smash_noc_router_buf #(
        .ADDR_SIZE(2), .DATA_SIZE(32), .NUM_ROWS(4), .NUM_COLUMNS(4),
        .ROUTER_ROW_ADDR(1), .ROUTER_COL_ADDR(2), .FIFO_DEPTH(4)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_flit(iflit),
        .o_ready(oready), .o_valid(ovalid), .o_flit(oflit), .i_ready(iready)
`ifdef SMASH_NOC_STATS_EN
        , .o_drop_cnt(dc)
`endif
    );

    smash_noc_router_buf #(
        .ADDR_SIZE(2), .DATA_SIZE(32), .NUM_ROWS(3), .NUM_COLUMNS(4),
        .ROUTER_ROW_ADDR(1), .ROUTER_COL_ADDR(2), .FIFO_DEPTH(4)
    ) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v3), .i_flit(f3),
        .o_ready(or3), .o_valid(ov3), .o_flit(of3), .i_ready(ir3)
`ifdef SMASH_NOC_STATS_EN
        , .o_drop_cnt(dc3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] mk(input int r, input int c, input logic [31:0] d);
        logic [1:0] rr, cc;
        rr = 2'(r);
        cc = 2'(c);
        return {rr, cc, d};
    endfunction

    // XY rule for a router at (1,2): columns first, then rows.
    function automatic int xy_port(input int r, input int c);
        if (c > 2) return 4;
        if (c < 2) return 3;
        if (r > 1) return 1;
        if (r < 1) return 2;
        return 0;
    endfunction

    task automatic do_reset();
        valid = '0; v3 = '0; iready = '1; ir3 = '1;
        rst_n = 1'b0;
        #1;
        chk("rst_o_valid", 64'(ovalid), 64'(0));
        chk("rst_o_flit_zero", 64'(|oflit), 64'(0));
        step();
        step();
        chk("rst_o_ready", 64'(oready), 64'h1f);
        chk("rst_dut3_o_valid", 64'(ov3), 64'(0));
`ifdef SMASH_NOC_STATS_EN
        chk("rst_drop_cnt", 64'(dc3), 64'(0));
`endif
        rst_n = 1'b1;
        step();
    endtask

    logic [35:0]  fl [6];
    int           ports [4];
    int           acc;
    logic [35:0]  sb [40][$];
    logic [4:0]   pre_or, pre_ov, pre_ir, pre_v;
    logic [179:0] pre_of, pre_if;
    logic [35:0]  got;
    int           qi, r_i, c_i, left;
    logic         quiet;

    initial begin
        n_checks = 0; n_fail = 0; seq = 0;
        rst_n = 1'b1; valid = '0; iflit = '0; iready = '1;
        v3 = '0; f3 = '0; ir3 = '1;
        #2;
        do_reset();

        // Local inject to (1,3): leaves on the right output one edge after push.
        fl[0] = mk(1, 3, 32'hDEADBEEF);
        valid[0] = 1'b1; iflit[0 +: FW] = fl[0];
        step();
        valid = '0;
        chk("lat_not_early", 64'(ovalid), 64'(0));
        step();
        chk("lat_valid_right", 64'(ovalid), 64'h10);
        chk("lat_flit_right", 64'(oflit[4*FW +: FW]), 64'(fl[0]));
        step();
        chk("lat_valid_clears", 64'(ovalid), 64'(0));

        // From the left port to up, down, local and left.
        fl[0] = mk(3, 2, 32'h11); fl[1] = mk(0, 2, 32'h22);
        fl[2] = mk(1, 2, 32'h33); fl[3] = mk(1, 0, 32'h44);
        ports[0] = 1; ports[1] = 2; ports[2] = 0; ports[3] = 3;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                valid[3] = 1'b1; iflit[3*FW +: FW] = fl[k];
            end else begin
                valid = '0;
            end
            step();
            if (k >= 1) begin
                chk("xy_valid", 64'(ovalid), 64'(1 << ports[k-1]));
                chk("xy_flit", 64'(oflit[ports[k-1]*FW +: FW]), 64'(fl[k-1]));
            end
        end
        step();
        chk("xy_idle", 64'(ovalid), 64'(0));

        // Round robin on the local output.
        do_reset();
        fl[0] = mk(1, 2, 32'hA1); fl[1] = mk(1, 2, 32'hA3);
        valid[1] = 1'b1; iflit[1*FW +: FW] = fl[0];
        valid[3] = 1'b1; iflit[3*FW +: FW] = fl[1];
        step();
        valid = '0;
        step();
        chk("rr_first_up", 64'(oflit[0 +: FW]), 64'(fl[0]));
        chk("rr_first_valid", 64'(ovalid), 64'h01);
        step();
        chk("rr_second_left", 64'(oflit[0 +: FW]), 64'(fl[1]));
        fl[2] = mk(1, 2, 32'hB0); fl[3] = mk(1, 2, 32'hB4);
        valid[0] = 1'b1; iflit[0 +: FW] = fl[2];
        valid[4] = 1'b1; iflit[4*FW +: FW] = fl[3];
        step();
        valid = '0;
        step();
        chk("rr_ptr4_right_first", 64'(oflit[0 +: FW]), 64'(fl[3]));
        step();
        chk("rr_then_local", 64'(oflit[0 +: FW]), 64'(fl[2]));
        step();
        chk("rr_idle", 64'(ovalid), 64'(0));

        // Backpressure on the right output with 6 offered flits.
        do_reset();
        iready[4] = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            fl[k] = mk(1, 3, 32'hC0 + 32'(k));
            valid[0] = 1'b1; iflit[0 +: FW] = fl[k];
            if (oready[0]) acc++;
            step();
        end
        valid = '0;
        chk("bp_accepted", 64'(acc), 64'(5));
        chk("bp_not_ready", 64'(oready[0]), 64'(0));
        chk("bp_valid", 64'(ovalid), 64'h10);
        step();
        chk("bp_flit_hold", 64'(oflit[4*FW +: FW]), 64'(fl[0]));
        iready[4] = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            chk("bp_drain_valid", 64'(ovalid[4]), 64'(1));
            chk("bp_drain_flit", 64'(oflit[4*FW +: FW]), 64'(fl[k]));
        end
        step();
        chk("bp_drain_done", 64'(ovalid), 64'(0));
        chk("bp_ready_back", 64'(oready), 64'h1f);

        // Out-of-mesh rows on the 3-row router are dropped.
        do_reset();
        v3[0] = 1'b1; f3[0 +: FW] = mk(3, 2, 32'hD0);
        step();
        f3[0 +: FW] = mk(1, 3, 32'hD1);
        step();
        v3 = '0;
        chk("drop_nothing_out", 64'(ov3), 64'(0));
        step();
        chk("drop_next_passes", 64'(ov3), 64'h10);
        chk("drop_next_flit", 64'(of3[4*FW +: FW]), 64'(mk(1, 3, 32'hD1)));
`ifdef SMASH_NOC_STATS_EN
        chk("drop_cnt_one", 64'(dc3), 64'(1));
`endif
        v3[1] = 1'b1; f3[1*FW +: FW] = mk(3, 0, 32'hD2);
        v3[2] = 1'b1; f3[2*FW +: FW] = mk(3, 3, 32'hD3);
        step();
        v3 = '0;
        chk("drop_pair_quiet0", 64'(ov3), 64'(0));
        step();
        chk("drop_pair_quiet1", 64'(ov3), 64'(0));
        step();
        chk("drop_pair_quiet2", 64'(ov3), 64'(0));
        chk("drop_ready", 64'(or3), 64'h1f);
`ifdef SMASH_NOC_STATS_EN
        chk("drop_cnt_three", 64'(dc3), 64'(3));
`endif

        // Randomized traffic with random downstream stalls, then a drain.
        do_reset();
        for (int cyc = 0; cyc < 460; cyc++) begin
            quiet = (cyc >= 400);
            for (int p = 0; p < 5; p++) begin
                r_i = int'($urandom_range(0, 3));
                c_i = int'($urandom_range(0, 3));
                valid[p] = !quiet && ($urandom_range(0, 99) < 45);
                iflit[p*FW +: FW] = mk(r_i, c_i, {3'(p), 29'(seq)});
                seq++;
            end
            for (int o = 0; o < 5; o++) iready[o] = quiet || ($urandom_range(0, 99) < 70);
            pre_or = oready; pre_ov = ovalid; pre_ir = iready;
            pre_of = oflit; pre_if = iflit; pre_v = valid;
            step();
            for (int o = 0; o < 5; o++) begin
                if (pre_ov[o] && pre_ir[o]) begin
                    got = pre_of[o*FW +: FW];
                    qi = int'(got[31:29]) * 5 + o;
                    chk("rand_flit_expected", 64'(sb[qi].size() != 0), 64'(1));
                    if (sb[qi].size() != 0) begin
                        chk("rand_order", 64'(got), 64'(sb[qi][0]));
                        void'(sb[qi].pop_front());
                    end
                end else if (pre_ov[o]) begin
                    chk("rand_stall_valid", 64'(ovalid[o]), 64'(1));
                    chk("rand_stall_flit", 64'(oflit[o*FW +: FW]), 64'(pre_of[o*FW +: FW]));
                end
            end
            for (int p = 0; p < 5; p++) begin
                if (pre_v[p] && pre_or[p]) begin
                    got = pre_if[p*FW +: FW];
                    sb[p*5 + xy_port(int'(got[35:34]), int'(got[33:32]))].push_back(got);
                end
            end
        end
        valid = '0;
        left = 0;
        for (int q = 0; q < 40; q++) left += sb[q].size();
        chk("rand_all_delivered", 64'(left), 64'(0));
        chk("rand_idle_after_drain", 64'(ovalid), 64'(0));

        // Reset while flits are buffered: everything is discarded.
        iready = '1;
        iready[4] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid[0] = 1'b1; iflit[0 +: FW] = mk(1, 3, 32'hE0 + 32'(k));
            step();
        end
        valid = '0;
        chk("mid_rst_pre_valid", 64'(ovalid), 64'h10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_now", 64'(ovalid), 64'(0));
        chk("mid_rst_ready_now", 64'(oready), 64'h1f);
        step();
        step();
        rst_n = 1'b1;
        iready = '1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mid_rst_no_stale", 64'(ovalid), 64'(0));
        end
        chk("mid_rst_ready_after", 64'(oready), 64'h1f);
`ifdef SMASH_NOC_STATS_EN
        chk("main_no_drops", 64'(dc), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
